// File: rtl/dec_4to16_seq.sv
// Sequenced 4-to-16 decoder.
//
// Accepts one request (bit index + hold length) at a time and drives a registered
// one-hot code on Y for the requested number of cycles. After the hold expires the
// block spends one GAP cycle with Y=0 and a done pulse, then returns to IDLE.
//
// Parameters:
//   HOLD_W    width of the hold-length field (max hold 2^HOLD_W-1 cycles)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  request fields are valid
//   in_ready  request is accepted this cycle (only high in IDLE)
//   in_idx    bit index to decode
//   in_len    hold length in cycles; 0 is treated as 1
//   sweep     (DEC_SWEEP_EN only) walk the index up to 15, one hold per code
//   Y         registered one-hot decode, or all zero
//   busy      high whenever not IDLE
//   done      one-cycle pulse in the GAP cycle ending a request
//
// Optional feature: define DEC_SWEEP_EN to add the sweep input and its logic.
module dec_4to16_seq #(
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_idx,
  input  logic [HOLD_W-1:0] in_len,
`ifdef DEC_SWEEP_EN
  input  logic              sweep,
`endif
  output logic [15:0]       Y,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2
  } state_e;

  localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] len_q, len_d;   // effective hold, never zero once loaded
  logic [HOLD_W-1:0] cnt_q, cnt_d;   // cycles of the current code still to hold
  logic [15:0]       y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic [HOLD_W-1:0] len_eff;
  logic              sweep_active;

`ifdef DEC_SWEEP_EN
  logic sweep_q, sweep_d;
  assign sweep_active = sweep_q;
`else
  assign sweep_active = 1'b0;
`endif

  // ready_q is only ever high while in IDLE, so it alone qualifies acceptance.
  assign accept  = in_valid && ready_q;
  assign len_eff = (in_len == '0) ? HoldOne : in_len;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef DEC_SWEEP_EN
    sweep_d = sweep_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d   = in_idx;
          len_d   = len_eff;
          cnt_d   = len_eff;
          state_d = StDrive;
`ifdef DEC_SWEEP_EN
          sweep_d = sweep;
`endif
        end
      end
      StDrive: begin
        if (cnt_q == HoldOne) begin
          if (sweep_active && (idx_q != 4'hF)) begin
            // Move straight to the next code with no zero cycle in between.
            idx_d = idx_q + 4'd1;
            cnt_d = len_q;
          end else begin
            cnt_d   = '0;
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q - HoldOne;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are computed from the next state so they are registered with it.
    y_d     = (state_d == StDrive) ? (16'd1 << idx_d) : 16'd0;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StGap);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
`ifdef DEC_SWEEP_EN
      sweep_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef DEC_SWEEP_EN
      sweep_q <= sweep_d;
`endif
    end
  end

  assign Y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = ready_q;

endmodule

// File: tb/tb_dec_4to16_seq.sv
// Self-checking bench for dec_4to16_seq: directed table, hand-written corner
// sequences and randomized requests against a per-cycle expected-Y model.
module tb_dec_4to16_seq;

  localparam int unsigned HoldW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_idx;
  logic [HoldW-1:0] in_len;
  logic [15:0]      y;
  logic             busy;
  logic             done;
`ifdef DEC_SWEEP_EN
  logic             sweep;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_4to16_seq #(
    .HOLD_W (HoldW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_len   (in_len),
`ifdef DEC_SWEEP_EN
    .sweep    (sweep),
`endif
    .Y        (y),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [3:0]  len;
    bit          sw;
    logic [15:0] exp_y;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_sweep(input bit s);
`ifdef DEC_SWEEP_EN
    sweep = s;
`else
    if (s) $display("note: sweep not built, request runs as sweep=0");
`endif
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      step();
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one request and check every cycle of it against the expected Y trace.
  task automatic run_req(input logic [3:0] idx, input logic [3:0] len, input bit sw,
                         output logic [15:0] first_y, output int drive_cnt);
    int exp_q[$];
    int h;
    int code;
    bit last;
    h    = (len == 4'd0) ? 1 : int'(len);
    code = int'(idx);
    do begin
      repeat (h) exp_q.push_back(1 << code);
      last = !sw || (code == 15);
      code++;
    end while (!last);

    wait_ready();
    in_valid = 1'b1;
    in_idx   = idx;
    in_len   = len;
    set_sweep(sw);
    step();
    first_y   = y;
    drive_cnt = 0;
    foreach (exp_q[i]) begin
      chk("drive_y", {16'd0, y}, exp_q[i]);
      chk("drive_onehot", $countones(y), 32'd1);
      chk("drive_busy_done_ready", {29'd0, busy, done, in_ready}, 32'b100);
      if (y != 16'd0) drive_cnt++;
      // Anything on the request inputs outside IDLE must be ignored.
      in_valid = 1'($urandom);
      in_idx   = 4'($urandom);
      in_len   = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    chk("gap_y", {16'd0, y}, 32'd0);
    chk("gap_busy_done_ready", {29'd0, busy, done, in_ready}, 32'b110);
    step();
    chk("idle_y", {16'd0, y}, 32'd0);
    chk("idle_busy_done_ready", {29'd0, busy, done, in_ready}, 32'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] fy;
    int          dc;
    logic [3:0]  rlen;
    bit          rsw;

    vecs.push_back('{idx: 4'd5,  len: 4'd3,  sw: 1'b0, exp_y: 16'h0020, exp_cnt: 3});
    vecs.push_back('{idx: 4'd15, len: 4'd0,  sw: 1'b0, exp_y: 16'h8000, exp_cnt: 1});
    vecs.push_back('{idx: 4'd0,  len: 4'd1,  sw: 1'b0, exp_y: 16'h0001, exp_cnt: 1});
    vecs.push_back('{idx: 4'd10, len: 4'd15, sw: 1'b0, exp_y: 16'h0400, exp_cnt: 15});
    vecs.push_back('{idx: 4'd7,  len: 4'd2,  sw: 1'b0, exp_y: 16'h0080, exp_cnt: 2});
`ifdef DEC_SWEEP_EN
    vecs.push_back('{idx: 4'd13, len: 4'd2,  sw: 1'b1, exp_y: 16'h2000, exp_cnt: 6});
    vecs.push_back('{idx: 4'd15, len: 4'd3,  sw: 1'b1, exp_y: 16'h8000, exp_cnt: 3});
`endif

    // Reset state.
    rst      = 1'b1;
    in_valid = 1'b0;
    in_idx   = 4'($urandom);
    in_len   = 4'($urandom);
    set_sweep(1'b0);
    step();
    step();
    chk("reset_y", {16'd0, y}, 32'd0);
    chk("reset_busy_done_ready", {29'd0, busy, done, in_ready}, 32'b000);
    rst = 1'b0;
    chk("ready_before_first_edge", {31'd0, in_ready}, 32'd0);
    step();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Idle with in_valid=0 and junk on the request fields: nothing starts.
    for (int i = 0; i < 4; i++) begin
      in_idx = 4'($urandom);
      in_len = 4'($urandom);
      step();
      chk("idle_ignore_y", {16'd0, y}, 32'd0);
      chk("idle_ignore_busy", {31'd0, busy}, 32'd0);
    end

    // Directed table.
    foreach (vecs[i]) begin
      run_req(vecs[i].idx, vecs[i].len, vecs[i].sw, fy, dc);
      chk("table_first_y", {16'd0, fy}, {16'd0, vecs[i].exp_y});
      chk("table_drive_cnt", dc, vecs[i].exp_cnt);
    end

    // in_valid held through a request: the second one waits for IDLE.
    wait_ready();
    in_valid = 1'b1;
    in_idx   = 4'd2;
    in_len   = 4'd3;
    step();
    in_idx = 4'd9;
    in_len = 4'd1;
    for (int k = 0; k < 3; k++) begin
      chk("hold_first_y", {16'd0, y}, 32'h0004);
      chk("hold_first_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("hold_gap", {16'd0, y, 15'd0, done}, {16'd0, 16'd0, 15'd0, 1'b1});
    step();
    chk("hold_idle", {16'd0, y, 15'd0, in_ready}, {16'd0, 16'd0, 15'd0, 1'b1});
    step();
    chk("hold_second_y", {16'd0, y}, 32'h0200);
    in_valid = 1'b0;
    step();
    chk("hold_second_done", {31'd0, done}, 32'd1);
    step();

    // Reset during the 2nd cycle of a 4-cycle DRIVE.
    wait_ready();
    in_valid = 1'b1;
    in_idx   = 4'd7;
    in_len   = 4'd4;
    step();
    in_valid = 1'b0;
    chk("abort_cycle1_y", {16'd0, y}, 32'h0080);
    step();
    chk("abort_cycle2_y", {16'd0, y}, 32'h0080);
    #2 rst = 1'b1;
    #1;
    chk("abort_async_y", {16'd0, y}, 32'd0);
    chk("abort_async_busy_done_ready", {29'd0, busy, done, in_ready}, 32'b000);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_y_zero", {16'd0, y}, 32'd0);
    end
    chk("abort_ready", {31'd0, in_ready}, 32'd1);

    // Random requests covering every index.
    for (int i = 0; i < 16; i++) begin
      rlen = 4'($urandom_range(0, 15));
`ifdef DEC_SWEEP_EN
      rsw = 1'($urandom);
`else
      rsw = 1'b0;
`endif
      run_req(4'(i), rlen, rsw, fy, dc);
      chk("rand_first_y", {16'd0, fy}, 32'd1 << i);
      chk("rand_drive_cnt", dc,
          ((rlen == 4'd0) ? 1 : int'(rlen)) * (rsw ? (16 - i) : 1));
      repeat ($urandom_range(0, 2)) begin
        in_idx = 4'($urandom);
        in_len = 4'($urandom);
        step();
        chk("rand_idle_y", {16'd0, y}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
